ifetch_unit: RTL and testbench

Instruction fetch stage placed directly upstream of the processor core: holds the program counter, reads 32-bit instruction words from a synchronous instruction memory, and presents them to the core's IR through a valid/ready handshake. A 2-entry prefetch buffer sustains one instruction per cycle. A redirect port from the core handles resolved `jump`/`jcarry`…`jnooverflow` outcomes by flushing and refetching.

---
 rtl/ifetch_pkg.sv | 71 +++++++
 rtl/ifetch_fifo2.sv | 65 ++++++
 rtl/ifetch_unit.sv | 118 +++++++++++
 tb/tb_ifetch_unit.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ifetch_pkg
//  Description : Shared definitions for the instruction fetch stage: word
//                width, default PC width, opcode encodings and IR field
//                extraction helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package ifetch_pkg;

    localparam int INSTR_W      = 32;
    localparam int PC_W_DEFAULT = 5;

    // Opcode space carried in IR[31:27]
    typedef enum logic [4:0] {
        OP_MOVSGPR     = 5'd0,
        OP_MOV         = 5'd1,
        OP_ADD         = 5'd2,
        OP_SUB         = 5'd3,
        OP_MUL         = 5'd4,
        OP_ROR         = 5'd5,
        OP_RAND        = 5'd6,
        OP_AND         = 5'd7,
        OP_XOR         = 5'd8,
        OP_XNOR        = 5'd9,
        OP_NAND        = 5'd10,
        OP_NOR         = 5'd11,
        OP_NOT         = 5'd12,
        OP_STOREREG    = 5'd13,
        OP_STOREDIN    = 5'd14,
        OP_SENDDOUT    = 5'd15,
        OP_SENDREG     = 5'd16,
        OP_JUMP        = 5'd17,
        OP_JCARRY      = 5'd18,
        OP_JNOCARRY    = 5'd19,
        OP_JSIGN       = 5'd20,
        OP_JNOSIGN     = 5'd21,
        OP_JZERO       = 5'd22,
        OP_JNOZERO     = 5'd23,
        OP_JOVERFLOW   = 5'd24,
        OP_JNOOVERFLOW = 5'd25,
        OP_HALT        = 5'd26
    } opcode_e;

    // IR field extraction
    function automatic logic [4:0] ir_oper_type(input logic [INSTR_W-1:0] w);
        return w[31:27];
    endfunction

    function automatic logic [4:0] ir_rdst(input logic [INSTR_W-1:0] w);
        return w[26:22];
    endfunction

    function automatic logic [4:0] ir_rsrc1(input logic [INSTR_W-1:0] w);
        return w[21:17];
    endfunction

    function automatic logic ir_imm_mode(input logic [INSTR_W-1:0] w);
        return w[16];
    endfunction

    function automatic logic [4:0] ir_rsrc2(input logic [INSTR_W-1:0] w);
        return w[15:11];
    endfunction

    function automatic logic [15:0] ir_isrc(input logic [INSTR_W-1:0] w);
        return w[15:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/ifetch_fifo2.sv
`default_nettype none
// ============================================================================
//  Module      : ifetch_fifo2
//  Description : Two-entry prefetch FIFO of {pc, instruction word} with
//                push, pop, flush and occupancy count.
//  Revision    : 1.0 - initial release
// ============================================================================
module ifetch_fifo2
    import ifetch_pkg::*;
#(
    parameter int PC_W = PC_W_DEFAULT
) (
    input  logic               clk,
    input  logic               sys_rst,
    input  logic               push_i,
    input  logic [PC_W-1:0]    push_pc_i,
    input  logic [INSTR_W-1:0] push_data_i,
    input  logic               pop_i,
    input  logic               flush_i,
    output logic [PC_W-1:0]    head_pc_o,
    output logic [INSTR_W-1:0] head_data_o,
    output logic [1:0]         count_o
);

    logic [PC_W-1:0]    pc_mem_q   [2];
    logic [INSTR_W-1:0] data_mem_q [2];
    logic               rd_ptr_q;
    logic               wr_ptr_q;
    logic [1:0]         count_q;

    // Pointer and occupancy bookkeeping; flush wins over any push/pop
    always_ff @(posedge clk) begin
        if (!sys_rst) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else if (flush_i) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push_i) begin
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (pop_i) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + {1'b0, push_i} - {1'b0, pop_i};
        end
    end

    // Storage array; contents are don't-care while the slot is empty
    always_ff @(posedge clk) begin
        if (push_i && !flush_i) begin
            pc_mem_q[wr_ptr_q]   <= push_pc_i;
            data_mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign head_pc_o   = pc_mem_q[rd_ptr_q];
    assign head_data_o = data_mem_q[rd_ptr_q];
    assign count_o     = count_q;

endmodule
`default_nettype wire

// File: rtl/ifetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : ifetch_unit
//  Description : Instruction fetch stage. Owns the PC, issues reads to a
//                synchronous instruction memory, buffers responses in a
//                two-entry FIFO and hands words to the core over a
//                valid/ready handshake. Redirects flush and refetch.
//  Revision    : 1.0 - initial release
// ============================================================================
module ifetch_unit
    import ifetch_pkg::*;
#(
    parameter int PC_W     = PC_W_DEFAULT,
    parameter int RESET_PC = 0
) (
    input  logic               clk,
    input  logic               sys_rst,
    input  logic               fetch_en,
    output logic               imem_en,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] ir,
    output logic [PC_W-1:0]    ir_pc,
    output logic               ir_valid,
    input  logic               ir_ready,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc
);

    localparam logic [0:0]      ST_IDLE = 1'b0;
    localparam logic [0:0]      ST_RUN  = 1'b1;
    localparam logic [PC_W-1:0] PC_RST  = PC_W'(RESET_PC);

    logic [PC_W-1:0]    pc_q;
    logic [PC_W-1:0]    pc_d;
    logic [PC_W-1:0]    tag_q;
    logic               inflight_q;
    logic [0:0]         state_d;
    logic               pop;
    logic               push;
    logic               issue;
    logic [1:0]         count;
    logic [2:0]         occupancy;
    logic [PC_W-1:0]    head_pc;
    logic [INSTR_W-1:0] head_data;

    // The state follows fetch_en within the same cycle so that the very first
    // cycle out of reset can already issue; it only gates new reads.
    always_comb begin
        state_d = (fetch_en) ? ST_RUN : ST_IDLE;
    end

    assign ir_valid = (count != 2'd0);
    assign pop      = ir_valid & ir_ready;

    // A response arriving during a redirect belongs to the old path
    assign push = inflight_q & ~redirect_valid;

    // Slots that will be taken once this cycle's response lands and pop retires;
    // issuing only below two guarantees room for the response we launch now.
    assign occupancy = {1'b0, count} + {2'b0, inflight_q} - {2'b0, pop};

    // Issue decision; reads are held off while reset is asserted
    always_comb begin
        issue = 1'b0;
        if (sys_rst && (state_d == ST_RUN) && !redirect_valid && (occupancy < 3'd2)) begin
            issue = 1'b1;
        end
    end

    assign imem_en   = issue;
    assign imem_addr = pc_q;

    // Next PC: redirect target, sequential increment (wraps naturally), or hold
    always_comb begin
        pc_d = pc_q;
        if (redirect_valid) begin
            pc_d = redirect_pc;
        end else if (issue) begin
            pc_d = pc_q + 1'b1;
        end
    end

    // PC, in-flight flag and tag of the outstanding read
    always_ff @(posedge clk) begin
        if (!sys_rst) begin
            pc_q       <= PC_RST;
            inflight_q <= 1'b0;
            tag_q      <= PC_RST;
        end else begin
            pc_q       <= pc_d;
            inflight_q <= issue;
            if (issue) begin
                tag_q <= pc_q;
            end
        end
    end

    ifetch_fifo2 #(
        .PC_W (PC_W)
    ) u_fifo (
        .clk         (clk),
        .sys_rst     (sys_rst),
        .push_i      (push),
        .push_pc_i   (tag_q),
        .push_data_i (imem_rdata),
        .pop_i       (pop),
        .flush_i     (redirect_valid),
        .head_pc_o   (head_pc),
        .head_data_o (head_data),
        .count_o     (count)
    );

    assign ir    = ir_valid ? head_data : '0;
    assign ir_pc = ir_valid ? head_pc   : '0;

endmodule
`default_nettype wire

// File: tb/tb_ifetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ifetch_unit
//  Description : Self-checking bench for ifetch_unit: cycle table for the
//                basic stream/redirect/wrap behaviour, hand sequences for
//                backpressure, fetch_en gaps and mid-stream reset, and a
//                random run against a program-order stream model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ifetch_unit;

    localparam int PC_W = 5;

    logic            clk = 1'b0;
    logic            sys_rst;
    logic            fetch_en;
    logic            imem_en;
    logic [PC_W-1:0] imem_addr;
    logic [31:0]     imem_rdata;
    logic [31:0]     ir;
    logic [PC_W-1:0] ir_pc;
    logic            ir_valid;
    logic            ir_ready;
    logic            redirect_valid;
    logic [PC_W-1:0] redirect_pc;

    logic [31:0] mem [32];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ifetch_unit #(
        .PC_W     (PC_W),
        .RESET_PC (0)
    ) dut (
        .clk            (clk),
        .sys_rst        (sys_rst),
        .fetch_en       (fetch_en),
        .imem_en        (imem_en),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .ir             (ir),
        .ir_pc          (ir_pc),
        .ir_valid       (ir_valid),
        .ir_ready       (ir_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    // Synchronous instruction memory: data one cycle after the strobe
    always @(posedge clk) begin
        if (imem_en) imem_rdata <= mem[imem_addr];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        sys_rst        = 1'b0;
        fetch_en       = 1'b0;
        ir_ready       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        cyc();
        cyc();
    endtask

    task automatic fill_linear_mem();
        for (int k = 0; k < 32; k++) mem[k] = 32'h1000_0000 + k;
    endtask

    // ------------------------------------------------------------------
    // Cycle table: inputs and expected outputs, cycle 0 = first cycle
    // with sys_rst high.
    // ------------------------------------------------------------------
    typedef struct {
        int fe;
        int rdy;
        int redir;
        int rpc;
        int en;
        int addr;
        int v;
        int pc;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input int fe, input int rdy, input int redir, input int rpc,
                       input int en, input int addr, input int v, input int pc);
        vec_t t;
        t.fe = fe; t.rdy = rdy; t.redir = redir; t.rpc = rpc;
        t.en = en; t.addr = addr; t.v = v; t.pc = pc;
        tbl.push_back(t);
    endtask

    // ------------------------------------------------------------------
    // Random-phase stream model: words leave in program order starting
    // from the reset PC; a redirect moves the expected next PC to the
    // target after any handshake of that same cycle.
    // ------------------------------------------------------------------
    bit              sb_on = 1'b0;
    logic [PC_W-1:0] exp_next;
    bit              prev_stall;
    logic [31:0]     prev_ir;
    logic [PC_W-1:0] prev_pc;
    int              quiet;

    always @(negedge clk) begin
        if (sb_on) begin
            if (!sys_rst) begin
                exp_next   = '0;
                prev_stall = 1'b0;
                quiet      = 0;
            end else begin
                if (prev_stall) begin
                    chk("stall_valid", 32'(ir_valid), 32'd1);
                    chk("stall_ir", ir, prev_ir);
                    chk("stall_pc", 32'(ir_pc), 32'(prev_pc));
                end
                if (quiet >= 2) chk("live_valid", 32'(ir_valid), 32'd1);
                quiet = (fetch_en && !redirect_valid) ? quiet + 1 : 0;
                if (ir_valid && ir_ready) begin
                    chk("stream_pc", 32'(ir_pc), 32'(exp_next));
                    chk("stream_ir", ir, mem[exp_next]);
                    exp_next = exp_next + 1'b1;
                end
                if (redirect_valid) exp_next = redirect_pc;
                prev_stall = ir_valid && !ir_ready && !redirect_valid;
                prev_ir    = ir;
                prev_pc    = ir_pc;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        fill_linear_mem();

        // ---------------- reset values ----------------
        do_reset();
        @(negedge clk);
        chk("rst_imem_en", 32'(imem_en), 32'd0);
        chk("rst_imem_addr", 32'(imem_addr), 32'd0);
        chk("rst_ir", ir, 32'd0);
        chk("rst_ir_pc", 32'(ir_pc), 32'd0);
        chk("rst_ir_valid", 32'(ir_valid), 32'd0);
        cyc();

        // ---------------- table: stream, redirect to 20, redirect to 30 (wrap) ----
        add(1,1,0, 0, 1, 0, 0, 0);
        add(1,1,0, 0, 1, 1, 0, 0);
        add(1,1,0, 0, 1, 2, 1, 0);
        add(1,1,0, 0, 1, 3, 1, 1);
        add(1,1,0, 0, 1, 4, 1, 2);
        add(1,1,0, 0, 1, 5, 1, 3);
        add(1,1,1,20, 0, 6, 1, 4);
        add(1,1,0, 0, 1,20, 0, 0);
        add(1,1,0, 0, 1,21, 0, 0);
        add(1,1,0, 0, 1,22, 1,20);
        add(1,1,0, 0, 1,23, 1,21);
        add(1,1,0, 0, 1,24, 1,22);
        add(1,1,1,30, 0,25, 1,23);
        add(1,1,0, 0, 1,30, 0, 0);
        add(1,1,0, 0, 1,31, 0, 0);
        add(1,1,0, 0, 1, 0, 1,30);
        add(1,1,0, 0, 1, 1, 1,31);
        add(1,1,0, 0, 1, 2, 1, 0);
        add(1,1,0, 0, 1, 3, 1, 1);

        sys_rst = 1'b1;
        foreach (tbl[i]) begin
            fetch_en       = (tbl[i].fe != 0);
            ir_ready       = (tbl[i].rdy != 0);
            redirect_valid = (tbl[i].redir != 0);
            redirect_pc    = PC_W'(tbl[i].rpc);
            @(negedge clk);
            chk("tbl_imem_en", 32'(imem_en), 32'(tbl[i].en));
            chk("tbl_imem_addr", 32'(imem_addr), 32'(tbl[i].addr));
            chk("tbl_ir_valid", 32'(ir_valid), 32'(tbl[i].v));
            chk("tbl_ir_pc", 32'(ir_pc), (tbl[i].v != 0) ? 32'(tbl[i].pc) : 32'd0);
            chk("tbl_ir", ir, (tbl[i].v != 0) ? 32'h1000_0000 + 32'(tbl[i].pc) : 32'd0);
            cyc();
        end
        redirect_valid = 1'b0;

        // ---------------- backpressure after first valid ----------------
        do_reset();
        sys_rst = 1'b1; fetch_en = 1'b1; ir_ready = 1'b1;
        cyc(); cyc();
        ir_ready = 1'b0;
        for (int c = 2; c <= 6; c++) begin
            @(negedge clk);
            chk("bp_imem_en", 32'(imem_en), 32'd0);
            chk("bp_valid", 32'(ir_valid), 32'd1);
            chk("bp_ir_pc", 32'(ir_pc), 32'd0);
            chk("bp_ir", ir, 32'h1000_0000);
            cyc();
        end
        ir_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_rel_valid", 32'(ir_valid), 32'd1);
            chk("bp_rel_pc", 32'(ir_pc), 32'(k));
            chk("bp_rel_ir", ir, 32'h1000_0000 + 32'(k));
            cyc();
        end

        // ---------------- fetch_en gap of 3 cycles ----------------
        do_reset();
        sys_rst = 1'b1; fetch_en = 1'b1; ir_ready = 1'b1;
        repeat (4) cyc();
        fetch_en = 1'b0;
        for (int c = 4; c <= 6; c++) begin
            @(negedge clk);
            chk("gap_imem_en", 32'(imem_en), 32'd0);
            chk("gap_valid", 32'(ir_valid), (c < 6) ? 32'd1 : 32'd0);
            if (c < 6) chk("gap_pc", 32'(ir_pc), 32'(c - 2));
            cyc();
        end
        fetch_en = 1'b1;
        @(negedge clk);
        chk("gap_resume_en", 32'(imem_en), 32'd1);
        chk("gap_resume_addr", 32'(imem_addr), 32'd4);
        cyc(); cyc();
        @(negedge clk);
        chk("gap_resume_pc", 32'(ir_pc), 32'd4);
        chk("gap_resume_valid", 32'(ir_valid), 32'd1);
        cyc();

        // ---------------- one-cycle reset mid-stream ----------------
        do_reset();
        sys_rst = 1'b1; fetch_en = 1'b1; ir_ready = 1'b1;
        repeat (4) cyc();
        sys_rst = 1'b0;
        @(negedge clk);
        chk("mrst_no_issue", 32'(imem_en), 32'd0);
        cyc();
        sys_rst = 1'b1;
        @(negedge clk);
        chk("mrst_valid", 32'(ir_valid), 32'd0);
        chk("mrst_ir", ir, 32'd0);
        chk("mrst_ir_pc", 32'(ir_pc), 32'd0);
        chk("mrst_addr", 32'(imem_addr), 32'd0);
        chk("mrst_en", 32'(imem_en), 32'd1);
        cyc();
        @(negedge clk);
        chk("mrst_valid_c1", 32'(ir_valid), 32'd0);
        cyc();
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("mrst_restart_pc", 32'(ir_pc), 32'(k));
            chk("mrst_restart_ir", ir, 32'h1000_0000 + 32'(k));
            cyc();
        end

        // ---------------- randomized run against the stream model ----------------
        for (int k = 0; k < 32; k++) mem[k] = $urandom;
        sb_on = 1'b1;
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            sys_rst        = ($urandom_range(0, 299) != 0);
            fetch_en       = ($urandom_range(0, 9) != 0);
            ir_ready       = ($urandom_range(0, 9) < 7);
            redirect_valid = ($urandom_range(0, 19) == 0);
            redirect_pc    = PC_W'($urandom_range(0, 31));
            cyc();
        end
        sb_on = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
